// File: rtl/exc_commit.sv
// Exception/ERET commit unit: captures a MEM-stage exception or ERET and pulses it to CP0.
// It then holds the pipeline flushed until the fetch redirect is accepted.
module exc_commit (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        stall_in,
    input  logic [31:0] pc_in,
    input  logic        bd_in,
    input  logic [31:0] mem_addr_in,
    input  logic [6:0]  exc_flags_in,
    input  logic        eret_in,
    input  logic        interrupt_in,
    input  logic [31:0] epc_in,
    output logic        exc_out,
    output logic [4:0]  exc_code_out,
    output logic [31:0] badvaddr_out,
    output logic        bd_out,
    output logic [31:0] pc_out,
    output logic        eret_flush_out,
    output logic        flush_out,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_COMMIT   = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    localparam logic [4:0] CODE_INT  = 5'h00;
    localparam logic [4:0] CODE_ADEL = 5'h04;
    localparam logic [4:0] CODE_ADES = 5'h05;
    localparam logic [4:0] CODE_SYS  = 5'h08;
    localparam logic [4:0] CODE_BP   = 5'h09;
    localparam logic [4:0] CODE_RI   = 5'h0A;
    localparam logic [4:0] CODE_OV   = 5'h0C;

    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

    logic [1:0]  state_q, state_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        bd_q, bd_d;
    logic [31:0] pc_q, pc_d;
    logic        is_eret_q, is_eret_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic        any_exc;
    logic        trigger;
    logic [4:0]  sel_code;
    logic [31:0] sel_badvaddr;

    // Priority encoder: interrupt first, then flags from bit 6 down to bit 0.
    always_comb begin
        any_exc      = interrupt_in || (|exc_flags_in);
        trigger      = valid_in && !stall_in && (state_q == ST_IDLE) && (any_exc || eret_in);
        sel_code     = CODE_INT;
        sel_badvaddr = 32'h0;
        if (interrupt_in) begin
            sel_code = CODE_INT;
        end else if (exc_flags_in[6]) begin
            sel_code     = CODE_ADEL;
            sel_badvaddr = pc_in;
        end else if (exc_flags_in[5]) begin
            sel_code = CODE_RI;
        end else if (exc_flags_in[4]) begin
            sel_code = CODE_OV;
        end else if (exc_flags_in[3]) begin
            sel_code = CODE_SYS;
        end else if (exc_flags_in[2]) begin
            sel_code = CODE_BP;
        end else if (exc_flags_in[1]) begin
            sel_code     = CODE_ADEL;
            sel_badvaddr = mem_addr_in;
        end else if (exc_flags_in[0]) begin
            sel_code     = CODE_ADES;
            sel_badvaddr = mem_addr_in;
        end
    end

    always_comb begin
        state_d       = state_q;
        code_d        = code_q;
        badvaddr_d    = badvaddr_q;
        bd_d          = bd_q;
        pc_d          = pc_q;
        is_eret_d     = is_eret_q;
        redirect_pc_d = redirect_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d    = ST_COMMIT;
                    code_d     = sel_code;
                    badvaddr_d = sel_badvaddr;
                    bd_d       = bd_in;
                    pc_d       = pc_in;
                    // Any exception on the same instruction overrides its ERET.
                    is_eret_d  = !any_exc;
                end
            end
            ST_COMMIT: begin
                state_d       = ST_REDIRECT;
                redirect_pc_d = is_eret_q ? epc_in : EXC_VECTOR;
            end
            ST_REDIRECT: begin
                if (redirect_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            code_q        <= 5'h0;
            badvaddr_q    <= 32'h0;
            bd_q          <= 1'b0;
            pc_q          <= 32'h0;
            is_eret_q     <= 1'b0;
            redirect_pc_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            code_q        <= code_d;
            badvaddr_q    <= badvaddr_d;
            bd_q          <= bd_d;
            pc_q          <= pc_d;
            is_eret_q     <= is_eret_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign exc_out        = (state_q == ST_COMMIT) && !is_eret_q;
    assign eret_flush_out = (state_q == ST_COMMIT) && is_eret_q;
    assign flush_out      = (state_q != ST_IDLE);
    assign busy           = (state_q != ST_IDLE);
    assign redirect_valid = (state_q == ST_REDIRECT);
    assign redirect_pc    = redirect_pc_q;
    assign exc_code_out   = code_q;
    assign badvaddr_out   = badvaddr_q;
    assign bd_out         = bd_q;
    assign pc_out         = pc_q;

endmodule

// File: tb/tb_exc_commit.sv
// Directed bench for exc_commit: priority, badvaddr selection, ERET, hold-off and reset abort.
module tb_exc_commit;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        stall_in;
    logic [31:0] pc_in;
    logic        bd_in;
    logic [31:0] mem_addr_in;
    logic [6:0]  exc_flags_in;
    logic        eret_in;
    logic        interrupt_in;
    logic [31:0] epc_in;
    logic        exc_out;
    logic [4:0]  exc_code_out;
    logic [31:0] badvaddr_out;
    logic        bd_out;
    logic [31:0] pc_out;
    logic        eret_flush_out;
    logic        flush_out;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        busy;

    int n_checks;
    int n_fails;

    exc_commit dut (
        .clk            (clk),
        .rst            (rst),
        .valid_in       (valid_in),
        .stall_in       (stall_in),
        .pc_in          (pc_in),
        .bd_in          (bd_in),
        .mem_addr_in    (mem_addr_in),
        .exc_flags_in   (exc_flags_in),
        .eret_in        (eret_in),
        .interrupt_in   (interrupt_in),
        .epc_in         (epc_in),
        .exc_out        (exc_out),
        .exc_code_out   (exc_code_out),
        .badvaddr_out   (badvaddr_out),
        .bd_out         (bd_out),
        .pc_out         (pc_out),
        .eret_flush_out (eret_flush_out),
        .flush_out      (flush_out),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        valid_in     = 1'b0;
        stall_in     = 1'b0;
        exc_flags_in = 7'b0;
        eret_in      = 1'b0;
        interrupt_in = 1'b0;
        bd_in        = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b1;
        clear_inputs();
        pc_in = 32'h0; mem_addr_in = 32'h0; epc_in = 32'h0; redirect_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_exc", exc_out, 0);
        chk("rst_eret", eret_flush_out, 0);
        chk("rst_flush", flush_out, 0);
        chk("rst_rv", redirect_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_code", exc_code_out, 0);
        chk("rst_bad", badvaddr_out, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_bd", bd_out, 0);
        chk("rst_rpc", redirect_pc, 0);
        $display("txn reset done");

        // ov + ades: ov wins, no badvaddr
        valid_in = 1'b1; exc_flags_in = 7'b0010001;
        pc_in = 32'h8000_1000; mem_addr_in = 32'h1234_5678;
        step();
        clear_inputs();
        chk("ov_exc", exc_out, 1);
        chk("ov_code", exc_code_out, 5'h0C);
        chk("ov_bad", badvaddr_out, 0);
        chk("ov_pc", pc_out, 32'h8000_1000);
        chk("ov_flush", flush_out, 1);
        chk("ov_rv_commit", redirect_valid, 0);
        chk("ov_eret", eret_flush_out, 0);
        step();
        chk("ov_exc_off", exc_out, 0);
        chk("ov_rv", redirect_valid, 1);
        chk("ov_rpc", redirect_pc, 32'hBFC0_0380);
        chk("ov_flush_rd", flush_out, 1);
        chk("ov_busy_rd", busy, 1);
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        chk("ov_idle_busy", busy, 0);
        chk("ov_idle_rv", redirect_valid, 0);
        chk("ov_idle_flush", flush_out, 0);
        chk("ov_code_hold", exc_code_out, 5'h0C);
        $display("txn ov|ades code=%h rpc=%h", 5'h0C, 32'hBFC0_0380);

        // adel_ld with delay-slot flag
        valid_in = 1'b1; exc_flags_in = 7'b0000010; bd_in = 1'b1;
        mem_addr_in = 32'h8000_2003; pc_in = 32'h8000_3000;
        step();
        clear_inputs();
        chk("adel_ld_code", exc_code_out, 5'h04);
        chk("adel_ld_bad", badvaddr_out, 32'h8000_2003);
        chk("adel_ld_bd", bd_out, 1);
        chk("adel_ld_exc", exc_out, 1);
        redirect_ready = 1'b1;
        step();
        step();
        redirect_ready = 1'b0;
        chk("adel_ld_idle", busy, 0);
        chk("adel_ld_bd_hold", bd_out, 1);
        $display("txn adel_ld code=04 bad=%h", 32'h8000_2003);

        // adel_if + ri: adel_if wins, badvaddr is pc
        valid_in = 1'b1; exc_flags_in = 7'b1100000; pc_in = 32'h8000_4001; mem_addr_in = 32'h0;
        step();
        clear_inputs();
        chk("adel_if_code", exc_code_out, 5'h04);
        chk("adel_if_bad", badvaddr_out, 32'h8000_4001);
        chk("adel_if_bd", bd_out, 0);
        redirect_ready = 1'b1;
        step();
        step();
        redirect_ready = 1'b0;
        $display("txn adel_if code=04 bad=%h", 32'h8000_4001);

        // plain ERET
        valid_in = 1'b1; eret_in = 1'b1; epc_in = 32'h8000_0040; pc_in = 32'h8000_5000;
        step();
        clear_inputs();
        chk("eret_flush", eret_flush_out, 1);
        chk("eret_exc", exc_out, 0);
        chk("eret_busy", busy, 1);
        step();
        epc_in = 32'h1111_2222;
        chk("eret_flush_off", eret_flush_out, 0);
        chk("eret_rv", redirect_valid, 1);
        chk("eret_rpc", redirect_pc, 32'h8000_0040);
        step();
        chk("eret_rpc_hold", redirect_pc, 32'h8000_0040);
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        chk("eret_idle", busy, 0);
        $display("txn eret rpc=%h", 32'h8000_0040);

        // ERET together with bp: exception wins
        valid_in = 1'b1; eret_in = 1'b1; exc_flags_in = 7'b0000100; epc_in = 32'h8000_0080;
        step();
        clear_inputs();
        chk("eretbp_exc", exc_out, 1);
        chk("eretbp_eret", eret_flush_out, 0);
        chk("eretbp_code", exc_code_out, 5'h09);
        step();
        chk("eretbp_rpc", redirect_pc, 32'hBFC0_0380);
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        $display("txn eret+bp code=09");

        // interrupt + sys: interrupt wins
        valid_in = 1'b1; interrupt_in = 1'b1; exc_flags_in = 7'b0001000;
        step();
        clear_inputs();
        chk("int_code", exc_code_out, 5'h00);
        chk("int_exc", exc_out, 1);
        redirect_ready = 1'b1;
        step();
        step();
        redirect_ready = 1'b0;
        chk("int_idle", busy, 0);
        $display("txn int+sys code=00");

        // interrupt while stalled or invalid: no trigger
        valid_in = 1'b1; stall_in = 1'b1; interrupt_in = 1'b1;
        step();
        chk("stall_busy", busy, 0);
        chk("stall_exc", exc_out, 0);
        stall_in = 1'b0; valid_in = 1'b0;
        step();
        clear_inputs();
        chk("novalid_busy", busy, 0);
        chk("novalid_exc", exc_out, 0);
        $display("txn int stalled/invalid no trigger");

        // bp then redirect held off for 5 cycles with new triggers applied
        valid_in = 1'b1; exc_flags_in = 7'b0000100; pc_in = 32'h8000_6000;
        step();
        chk("hold_code", exc_code_out, 5'h09);
        valid_in = 1'b1; interrupt_in = 1'b1; exc_flags_in = 7'b0001000; pc_in = 32'h8000_7000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_rv", redirect_valid, 1);
            chk("hold_flush", flush_out, 1);
            chk("hold_rpc", redirect_pc, 32'hBFC0_0380);
            chk("hold_exc", exc_out, 0);
            chk("hold_pc", pc_out, 32'h8000_6000);
        end
        clear_inputs();
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        chk("hold_idle", busy, 0);
        chk("hold_code_kept", exc_code_out, 5'h09);
        $display("txn hold 5 cycles code=09");

        // reset mid-REDIRECT
        valid_in = 1'b1; exc_flags_in = 7'b0100000; bd_in = 1'b1; pc_in = 32'h8000_8000;
        step();
        clear_inputs();
        step();
        chk("abort_pre_rv", redirect_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_exc", exc_out, 0);
        chk("abort_eret", eret_flush_out, 0);
        chk("abort_flush", flush_out, 0);
        chk("abort_rv", redirect_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_code", exc_code_out, 0);
        chk("abort_pc", pc_out, 0);
        chk("abort_bd", bd_out, 0);
        chk("abort_rpc", redirect_pc, 0);
        $display("txn reset in redirect");

        // fresh trigger after reset: ades
        valid_in = 1'b1; exc_flags_in = 7'b0000001; mem_addr_in = 32'h8000_5005;
        step();
        clear_inputs();
        chk("ades_exc", exc_out, 1);
        chk("ades_code", exc_code_out, 5'h05);
        chk("ades_bad", badvaddr_out, 32'h8000_5005);
        step();
        chk("ades_rv", redirect_valid, 1);
        $display("txn ades code=05 bad=%h", 32'h8000_5005);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
